l2tlb_xlate: RTL and testbench
==============================

L2TLB_XLATE -- requirements
Module: l2tlb_xlate

Interface
REQ-001 Parameters (name, default, meaning): NUM_ENTRIES, 16, TLB entries, power of 2, range 4..64; NUM_SLOTS, 4, SPTBR slots tracked; VPN_W, 20, virtual page number width; PPN_W, 24, physical page number width; SPTBR_W, 32, SPTBR value width; RID_W, 3, requester id width.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, clock; reset, in, 1, asynchronous active-low reset, asserted at 0.
REQ-003 Ports: req_valid in 1; req_retry out 1; req_vpn in VPN_W; req_sptbr in SPTBR_W; req_rid in RID_W. These carry the L1TLB lookup request.
REQ-004 Ports: ack_valid out 1; ack_retry in 1; ack_rid out RID_W; ack_ppn out PPN_W; ack_fault out 2, where 00 is ok, 01 is walk fault and 10 is no slot; ack_hit out 1.
REQ-005 Ports: walk_valid out 1; walk_retry in 1; walk_vpn out VPN_W; walk_sptbr out SPTBR_W. These carry the miss request to the walker/directory.
REQ-006 Ports: fill_valid in 1; fill_retry out 1; fill_ppn in PPN_W; fill_fault in 1. These carry the walk response.
REQ-007 Ports: ckpt_valid in 1; ckpt_retry out 1; ckpt_sptbr in SPTBR_W. These carry the SPTBR checkpoint create.
REQ-008 Ports: snoop_valid out 1; snoop_retry in 1; snoop_sptbr out SPTBR_W. This is the L1TLB invalidate notification.

Function
REQ-009 Every channel SHALL use valid/retry: a transfer occurs in a cycle with valid=1 and retry=0; the sender holds valid and payload stable while retry=1.
REQ-010 FSM states SHALL be IDLE, RESP, WALK_REQ, WALK_WAIT and SNOOP.
REQ-011 In IDLE the block SHALL accept ckpt; a ckpt has priority over a req in the same cycle. req_retry SHALL be 1 whenever state!=IDLE or ckpt_valid=1, and ckpt_retry SHALL be 1 whenever state!=IDLE.
REQ-012 When a req is accepted at cycle T, req_sptbr SHALL be matched against the valid slots and {slot,vpn} against the valid entries, combinationally in T.
REQ-013 On a hit, ack_valid=1 at T+1 with ack_hit=1, ack_fault=00 and the entry ppn (state RESP).
REQ-014 On no matching slot, ack_valid=1 at T+1 with ack_fault=10, ack_hit=0 and ack_ppn=0; no walk is issued.
REQ-015 On a miss, walk_valid=1 at T+1 (state WALK_REQ). After the walk transfer the state SHALL be WALK_WAIT, with fill_retry=0.
REQ-016 When a fill is accepted at cycle F with fill_fault=0, the entry at the round-robin pointer SHALL be written at the end of F, the pointer SHALL increment modulo NUM_ENTRIES, and ack_valid=1 at F+1 with ack_hit=0 and ack_fault=00.
REQ-017 When a fill is accepted with fill_fault=1, no entry SHALL be written and ack_fault=01.
REQ-018 In RESP the block SHALL return to IDLE on the cycle the ack transfers.
REQ-019 A fill arriving outside WALK_WAIT SHALL be accepted (fill_retry=0) and dropped.
REQ-020 A ckpt whose sptbr matches a valid slot SHALL reuse that slot.
REQ-021 A ckpt whose sptbr matches no slot SHALL allocate the lowest free slot; if no slot is free it SHALL take the round-robin slot victim, and the victim pointer SHALL then increment modulo NUM_SLOTS.
REQ-022 At the end of the ckpt acceptance cycle, all entries tagged with the chosen slot SHALL be invalidated and the slot SHALL be loaded with ckpt_sptbr.
REQ-023 snoop_valid=1 the next cycle (state SNOOP) with snoop_sptbr equal to the evicted or reused slot's previous sptbr; the state SHALL return to IDLE on the snoop transfer.
REQ-024 Duplicate {slot,vpn} entries SHALL never be created, because only one miss is outstanding and fills only occur after a miss.

Reset
REQ-025 While reset=0: all outputs 0, except req_retry=1, ckpt_retry=1 and fill_retry=0. All entries and slots invalid, both pointers 0, state IDLE.
REQ-026 A reset asserted mid-walk or mid-snoop SHALL abandon the operation without issuing an ack or snoop.

Structure
REQ-027 The fault encoding, the state enum and the entry/slot record typedefs SHALL live in the shared package.
REQ-028 The match logic SHALL be one sub-module, l2tlb_cam, parametrised by NUM_ENTRIES, VPN_W and slot width, that outputs hit and a one-hot index.

Verification
REQ-029 Miss-fill-hit: reset; ckpt sptbr=0x1000; req vpn=0x12345 → walk vpn=0x12345 at T+1; fill ppn=0xABCDE → ack hit=0 ppn=0xABCDE. Repeat req → ack at T+1 with hit=1 and ppn=0xABCDE.
REQ-030 No slot: req sptbr=0x2000 with no ckpt → ack fault=10 at T+1; walk_valid stays 0.
REQ-031 Slot eviction: ckpt 0x1000, 0x2000, 0x3000, 0x4000, then 0x5000 → snoop sptbr=0x1000. A subsequent req sptbr=0x1000 → fault=10, and entries of 0x1000 are gone.
REQ-032 Backpressure: hold ack_retry=1 for 5 cycles → ack stable, req_retry=1 throughout; release → single ack and return to IDLE.
REQ-033 Fault and stale fill: fill_fault=1 → ack fault=01 and no entry installed; reset during WALK_WAIT followed by a late fill → fill accepted, no ack.

Source files
------------

// File: rtl/l2tlb_xlate_pkg.sv
// Shared types for the L2 TLB translate block: fault codes, FSM states and storage records.
package l2tlb_xlate_pkg;

    localparam int L2TLB_VPN_W   = 20;
    localparam int L2TLB_PPN_W   = 24;
    localparam int L2TLB_SPTBR_W = 32;
    localparam int L2TLB_SLOT_W  = 2;

    typedef enum logic [1:0] {
        FAULT_OK      = 2'b00,
        FAULT_WALK    = 2'b01,
        FAULT_NO_SLOT = 2'b10
    } fault_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESP,
        ST_WALK_REQ,
        ST_WALK_WAIT,
        ST_SNOOP
    } state_e;

    // Record widths track the block's default geometry; overriding widths means updating these too.
    typedef struct packed {
        logic                    valid;
        logic [L2TLB_SLOT_W-1:0] slot;
        logic [L2TLB_VPN_W-1:0]  vpn;
        logic [L2TLB_PPN_W-1:0]  ppn;
    } tlb_entry_t;

    typedef struct packed {
        logic                     valid;
        logic [L2TLB_SPTBR_W-1:0] sptbr;
    } sptbr_slot_t;

endpackage

// File: rtl/l2tlb_xlate_cam.sv
// Fully associative {slot,vpn} match over the TLB entries; one-hot hit vector.
module l2tlb_cam
    import l2tlb_xlate_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int VPN_W       = 20,
    parameter int SLOT_W      = 2
) (
    input  logic [NUM_ENTRIES-1:0]        entry_valid,
    input  logic [NUM_ENTRIES*SLOT_W-1:0] entry_slot,
    input  logic [NUM_ENTRIES*VPN_W-1:0]  entry_vpn,
    input  logic [SLOT_W-1:0]             key_slot,
    input  logic [VPN_W-1:0]              key_vpn,
    output logic                          hit,
    output logic [NUM_ENTRIES-1:0]        hit_onehot
);

    always_comb begin
        hit_onehot = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hit_onehot[i] = entry_valid[i]
                         && (entry_slot[i*SLOT_W +: SLOT_W] == key_slot)
                         && (entry_vpn[i*VPN_W +: VPN_W] == key_vpn);
        end
    end

    assign hit = |hit_onehot;

endmodule

// File: rtl/l2tlb_xlate.sv
// L2 TLB translate: SPTBR slot tracking, lookup, single outstanding walk, fill and L1 snoop.
//   state      | meaning
//   IDLE       | accept ckpt (priority) or lookup request
//   RESP       | ack presented, waiting for transfer
//   WALK_REQ   | miss request presented to walker
//   WALK_WAIT  | waiting for the walk fill
//   SNOOP      | L1 invalidate for the replaced slot presented
module l2tlb_xlate
    import l2tlb_xlate_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_SLOTS   = 4,
    parameter int VPN_W       = 20,
    parameter int PPN_W       = 24,
    parameter int SPTBR_W     = 32,
    parameter int RID_W       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_retry,
    input  logic [VPN_W-1:0]   req_vpn,
    input  logic [SPTBR_W-1:0] req_sptbr,
    input  logic [RID_W-1:0]   req_rid,
    output logic               ack_valid,
    input  logic               ack_retry,
    output logic [RID_W-1:0]   ack_rid,
    output logic [PPN_W-1:0]   ack_ppn,
    output logic [1:0]         ack_fault,
    output logic               ack_hit,
    output logic               walk_valid,
    input  logic               walk_retry,
    output logic [VPN_W-1:0]   walk_vpn,
    output logic [SPTBR_W-1:0] walk_sptbr,
    input  logic               fill_valid,
    output logic               fill_retry,
    input  logic [PPN_W-1:0]   fill_ppn,
    input  logic               fill_fault,
    input  logic               ckpt_valid,
    output logic               ckpt_retry,
    input  logic [SPTBR_W-1:0] ckpt_sptbr,
    output logic               snoop_valid,
    input  logic               snoop_retry,
    output logic [SPTBR_W-1:0] snoop_sptbr
);

    localparam int EIDX_W = $clog2(NUM_ENTRIES);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    state_e              state, state_nxt;
    tlb_entry_t          ent [NUM_ENTRIES];
    sptbr_slot_t         slt [NUM_SLOTS];
    logic [EIDX_W-1:0]   fill_ptr;
    logic [SLOT_W-1:0]   vict_ptr, cur_slot;

    logic                req_slot_hit, ckpt_hit, free_ok;
    logic [SLOT_W-1:0]   req_slot, ckpt_hit_slot, free_slot, ckpt_slot;
    logic [NUM_ENTRIES-1:0]        cam_valid, cam_onehot;
    logic [NUM_ENTRIES*SLOT_W-1:0] cam_slot;
    logic [NUM_ENTRIES*VPN_W-1:0]  cam_vpn;
    logic                cam_hit;
    logic [PPN_W-1:0]    hit_ppn;

    logic req_go, ckpt_go, fill_go;

    assign ckpt_go = (state == ST_IDLE) && ckpt_valid;
    assign req_go  = (state == ST_IDLE) && !ckpt_valid && req_valid;
    assign fill_go = (state == ST_WALK_WAIT) && fill_valid;

    // Descending scan so the lowest matching / free slot wins.
    always_comb begin
        req_slot_hit  = 1'b0;
        req_slot      = '0;
        ckpt_hit      = 1'b0;
        ckpt_hit_slot = '0;
        free_ok       = 1'b0;
        free_slot     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slt[i].valid && (slt[i].sptbr == req_sptbr)) begin
                req_slot_hit = 1'b1;
                req_slot     = SLOT_W'(i);
            end
            if (slt[i].valid && (slt[i].sptbr == ckpt_sptbr)) begin
                ckpt_hit      = 1'b1;
                ckpt_hit_slot = SLOT_W'(i);
            end
            if (!slt[i].valid) begin
                free_ok   = 1'b1;
                free_slot = SLOT_W'(i);
            end
        end
        if (ckpt_hit)     ckpt_slot = ckpt_hit_slot;
        else if (free_ok) ckpt_slot = free_slot;
        else              ckpt_slot = vict_ptr;
    end

    always_comb begin
        cam_valid = '0;
        cam_slot  = '0;
        cam_vpn   = '0;
        hit_ppn   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cam_valid[i]                 = ent[i].valid;
            cam_slot[i*SLOT_W +: SLOT_W] = ent[i].slot;
            cam_vpn[i*VPN_W +: VPN_W]    = ent[i].vpn;
            if (cam_onehot[i]) hit_ppn = hit_ppn | ent[i].ppn;
        end
    end

    l2tlb_cam #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .VPN_W       (VPN_W),
        .SLOT_W      (SLOT_W)
    ) u_cam (
        .entry_valid (cam_valid),
        .entry_slot  (cam_slot),
        .entry_vpn   (cam_vpn),
        .key_slot    (req_slot),
        .key_vpn     (req_vpn),
        .hit         (cam_hit),
        .hit_onehot  (cam_onehot)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ckpt_valid)
                    state_nxt = ST_SNOOP;
                else if (req_valid)
                    state_nxt = (req_slot_hit && !cam_hit) ? ST_WALK_REQ : ST_RESP;
            end
            ST_RESP:      if (!ack_retry)   state_nxt = ST_IDLE;
            ST_WALK_REQ:  if (!walk_retry)  state_nxt = ST_WALK_WAIT;
            ST_WALK_WAIT: if (fill_valid)   state_nxt = ST_RESP;
            ST_SNOOP:     if (!snoop_retry) state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    // Retries are forced high under reset so upstream cannot launch into a block that is clearing.
    assign req_retry   = !reset || (state != ST_IDLE) || ckpt_valid;
    assign ckpt_retry  = !reset || (state != ST_IDLE);
    assign fill_retry  = 1'b0;
    assign ack_valid   = (state == ST_RESP);
    assign walk_valid  = (state == ST_WALK_REQ);
    assign snoop_valid = (state == ST_SNOOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
            for (int i = 0; i < NUM_SLOTS; i++)   slt[i] <= '0;
            fill_ptr    <= '0;
            vict_ptr    <= '0;
            cur_slot    <= '0;
            ack_rid     <= '0;
            ack_ppn     <= '0;
            ack_fault   <= FAULT_OK;
            ack_hit     <= 1'b0;
            walk_vpn    <= '0;
            walk_sptbr  <= '0;
            snoop_sptbr <= '0;
        end else begin
            if (ckpt_go) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (ent[i].slot == ckpt_slot) ent[i].valid <= 1'b0;
                end
                slt[ckpt_slot] <= '{valid: 1'b1, sptbr: ckpt_sptbr};
                snoop_sptbr    <= slt[ckpt_slot].sptbr;
                if (!ckpt_hit && !free_ok)
                    vict_ptr <= (vict_ptr == SLOT_W'(NUM_SLOTS - 1)) ? '0 : vict_ptr + 1'b1;
            end
            if (req_go) begin
                ack_rid    <= req_rid;
                walk_vpn   <= req_vpn;
                walk_sptbr <= req_sptbr;
                cur_slot   <= req_slot;
                ack_hit    <= req_slot_hit && cam_hit;
                ack_fault  <= req_slot_hit ? FAULT_OK : FAULT_NO_SLOT;
                ack_ppn    <= (req_slot_hit && cam_hit) ? hit_ppn : '0;
            end
            if (fill_go) begin
                ack_hit <= 1'b0;
                if (fill_fault) begin
                    ack_fault <= FAULT_WALK;
                    ack_ppn   <= '0;
                end else begin
                    ent[fill_ptr] <= '{valid: 1'b1, slot: cur_slot, vpn: walk_vpn, ppn: fill_ppn};
                    fill_ptr      <= fill_ptr + 1'b1;
                    ack_fault     <= FAULT_OK;
                    ack_ppn       <= fill_ppn;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2tlb_xlate.sv
// Scoreboard bench for l2tlb_xlate: directed ckpt/req/fill sequences, monitors pop expected transfers.
module tb_l2tlb_xlate;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_retry;
    logic [19:0] req_vpn;
    logic [31:0] req_sptbr;
    logic [2:0]  req_rid;
    logic        ack_valid, ack_retry;
    logic [2:0]  ack_rid;
    logic [23:0] ack_ppn;
    logic [1:0]  ack_fault;
    logic        ack_hit;
    logic        walk_valid, walk_retry;
    logic [19:0] walk_vpn;
    logic [31:0] walk_sptbr;
    logic        fill_valid, fill_retry;
    logic [23:0] fill_ppn;
    logic        fill_fault;
    logic        ckpt_valid, ckpt_retry;
    logic [31:0] ckpt_sptbr;
    logic        snoop_valid, snoop_retry;
    logic [31:0] snoop_sptbr;

    always #5 clk = ~clk;

    l2tlb_xlate u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_retry   (req_retry),
        .req_vpn     (req_vpn),
        .req_sptbr   (req_sptbr),
        .req_rid     (req_rid),
        .ack_valid   (ack_valid),
        .ack_retry   (ack_retry),
        .ack_rid     (ack_rid),
        .ack_ppn     (ack_ppn),
        .ack_fault   (ack_fault),
        .ack_hit     (ack_hit),
        .walk_valid  (walk_valid),
        .walk_retry  (walk_retry),
        .walk_vpn    (walk_vpn),
        .walk_sptbr  (walk_sptbr),
        .fill_valid  (fill_valid),
        .fill_retry  (fill_retry),
        .fill_ppn    (fill_ppn),
        .fill_fault  (fill_fault),
        .ckpt_valid  (ckpt_valid),
        .ckpt_retry  (ckpt_retry),
        .ckpt_sptbr  (ckpt_sptbr),
        .snoop_valid (snoop_valid),
        .snoop_retry (snoop_retry),
        .snoop_sptbr (snoop_sptbr)
    );

    typedef struct {
        logic [2:0]  rid;
        logic [23:0] ppn;
        logic [1:0]  fault;
        logic        hit;
        bit          chk_ppn;
    } ack_exp_t;

    typedef struct {
        logic [19:0] vpn;
        logic [31:0] sptbr;
    } walk_exp_t;

    ack_exp_t    exp_ack[$];
    walk_exp_t   exp_walk[$];
    logic [31:0] exp_snoop[$];

    int n_chk = 0;
    int n_err = 0;
    int ack_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        ack_exp_t  ea;
        walk_exp_t ew;
        logic [31:0] es;
        if (reset) begin
            if (ack_valid && !ack_retry) begin
                ack_cnt++;
                if (exp_ack.size() == 0) chk("ack_unexpected", 64'(ack_valid), 64'd0);
                else begin
                    ea = exp_ack.pop_front();
                    chk("ack_rid", 64'(ack_rid), 64'(ea.rid));
                    if (ea.chk_ppn) chk("ack_ppn", 64'(ack_ppn), 64'(ea.ppn));
                    chk("ack_fault", 64'(ack_fault), 64'(ea.fault));
                    chk("ack_hit", 64'(ack_hit), 64'(ea.hit));
                end
            end
            if (walk_valid && !walk_retry) begin
                if (exp_walk.size() == 0) chk("walk_unexpected", 64'(walk_valid), 64'd0);
                else begin
                    ew = exp_walk.pop_front();
                    chk("walk_vpn", 64'(walk_vpn), 64'(ew.vpn));
                    chk("walk_sptbr", 64'(walk_sptbr), 64'(ew.sptbr));
                end
            end
            if (snoop_valid && !snoop_retry) begin
                if (exp_snoop.size() == 0) chk("snoop_unexpected", 64'(snoop_valid), 64'd0);
                else begin
                    es = exp_snoop.pop_front();
                    chk("snoop_sptbr", 64'(snoop_sptbr), 64'(es));
                end
            end
        end
    end

    task automatic push_ack(input logic [2:0] rid, input logic [23:0] ppn,
                            input logic [1:0] fault, input logic hit, input bit chk_ppn);
        ack_exp_t e;
        e.rid = rid; e.ppn = ppn; e.fault = fault; e.hit = hit; e.chk_ppn = chk_ppn;
        exp_ack.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (req_retry && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_retry) chk({tag, "_idle_timeout"}, 64'(req_retry), 64'd0);
    endtask

    // kind 0: ack expected at T+1; kind 1: walk expected at T+1
    task automatic do_req(input logic [19:0] vpn, input logic [31:0] sptbr,
                          input logic [2:0] rid, input int kind);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_vpn = vpn; req_sptbr = sptbr; req_rid = rid;
        @(negedge clk);
        while (req_retry && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_retry) chk("req_accept_timeout", 64'(req_retry), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        if (kind == 0) begin
            chk("ack_at_t1", 64'(ack_valid), 64'd1);
            chk("no_walk_at_t1", 64'(walk_valid), 64'd0);
        end else begin
            chk("walk_at_t1", 64'(walk_valid), 64'd1);
            chk("no_ack_on_miss", 64'(ack_valid), 64'd0);
        end
    endtask

    task automatic do_fill(input logic [23:0] ppn, input logic fault, input bit expect_ack);
        @(posedge clk); #1;
        fill_valid = 1'b1; fill_ppn = ppn; fill_fault = fault;
        @(negedge clk);
        chk("fill_retry", 64'(fill_retry), 64'd0);
        @(posedge clk); #1;
        fill_valid = 1'b0;
        @(negedge clk);
        chk("ack_after_fill", 64'(ack_valid), 64'(expect_ack));
    endtask

    task automatic do_ckpt(input logic [31:0] sptbr, input logic [31:0] prev);
        int n = 0;
        exp_snoop.push_back(prev);
        @(posedge clk); #1;
        ckpt_valid = 1'b1; ckpt_sptbr = sptbr;
        @(negedge clk);
        chk("req_retry_under_ckpt", 64'(req_retry), 64'd1);
        while (ckpt_retry && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ckpt_retry) chk("ckpt_accept_timeout", 64'(ckpt_retry), 64'd0);
        @(posedge clk); #1;
        ckpt_valid = 1'b0;
        @(negedge clk);
        chk("snoop_at_t1", 64'(snoop_valid), 64'd1);
        wait_idle("ckpt");
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_retry", 64'(req_retry), 64'd1);
        chk("rst_ckpt_retry", 64'(ckpt_retry), 64'd1);
        chk("rst_fill_retry", 64'(fill_retry), 64'd0);
        chk("rst_ack_valid", 64'(ack_valid), 64'd0);
        chk("rst_walk_valid", 64'(walk_valid), 64'd0);
        chk("rst_snoop_valid", 64'(snoop_valid), 64'd0);
        chk("rst_ack_ppn", 64'(ack_ppn), 64'd0);
        chk("rst_walk_vpn", 64'(walk_vpn), 64'd0);
        chk("rst_snoop_sptbr", 64'(snoop_sptbr), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        reset = 1'b0;
        req_valid = 0; req_vpn = '0; req_sptbr = '0; req_rid = '0;
        ack_retry = 0; walk_retry = 0; snoop_retry = 0;
        fill_valid = 0; fill_ppn = '0; fill_fault = 0;
        ckpt_valid = 0; ckpt_sptbr = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b1;
        wait_idle("post_reset");

        // no slot allocated yet
        push_ack(3'd1, 24'd0, 2'b10, 1'b0, 1);
        do_req(20'h00001, 32'h2000, 3'd1, 0);
        wait_idle("noslot");

        // miss, fill, then hit
        do_ckpt(32'h1000, 32'h0);
        exp_walk.push_back('{vpn: 20'h12345, sptbr: 32'h1000});
        push_ack(3'd2, 24'hABCDE, 2'b00, 1'b0, 1);
        do_req(20'h12345, 32'h1000, 3'd2, 1);
        do_fill(24'hABCDE, 1'b0, 1);
        wait_idle("fill");
        push_ack(3'd3, 24'hABCDE, 2'b00, 1'b1, 1);
        do_req(20'h12345, 32'h1000, 3'd3, 0);
        wait_idle("hit");

        // ack backpressure
        ack_retry = 1'b1;
        base = ack_cnt;
        push_ack(3'd4, 24'hABCDE, 2'b00, 1'b1, 1);
        do_req(20'h12345, 32'h1000, 3'd4, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ack_valid", 64'(ack_valid), 64'd1);
            chk("bp_ack_ppn", 64'(ack_ppn), 64'hABCDE);
            chk("bp_req_retry", 64'(req_retry), 64'd1);
        end
        @(posedge clk); #1;
        ack_retry = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_ack_drop", 64'(ack_valid), 64'd0);
        chk("bp_back_idle", 64'(req_retry), 64'd0);
        chk("bp_single_ack", 64'(ack_cnt - base), 64'd1);

        // faulting walk installs nothing
        exp_walk.push_back('{vpn: 20'h55555, sptbr: 32'h1000});
        push_ack(3'd5, 24'd0, 2'b01, 1'b0, 0);
        do_req(20'h55555, 32'h1000, 3'd5, 1);
        do_fill(24'h00777, 1'b1, 1);
        wait_idle("fault");
        exp_walk.push_back('{vpn: 20'h55555, sptbr: 32'h1000});
        push_ack(3'd6, 24'h00111, 2'b00, 1'b0, 1);
        do_req(20'h55555, 32'h1000, 3'd6, 1);
        do_fill(24'h00111, 1'b0, 1);
        wait_idle("refill");

        // stale fill in IDLE is swallowed
        do_fill(24'h00999, 1'b0, 0);

        // slot eviction
        do_ckpt(32'h2000, 32'h0);
        do_ckpt(32'h3000, 32'h0);
        do_ckpt(32'h4000, 32'h0);
        do_ckpt(32'h5000, 32'h1000);
        push_ack(3'd7, 24'd0, 2'b10, 1'b0, 1);
        do_req(20'h12345, 32'h1000, 3'd7, 0);
        wait_idle("evicted");
        exp_walk.push_back('{vpn: 20'h12345, sptbr: 32'h5000});
        push_ack(3'd0, 24'h00222, 2'b00, 1'b0, 1);
        do_req(20'h12345, 32'h5000, 3'd0, 1);
        do_fill(24'h00222, 1'b0, 1);
        wait_idle("new_slot_fill");
        do_ckpt(32'h3000, 32'h3000);

        // reset mid-walk, then a late fill
        exp_walk.push_back('{vpn: 20'h00999, sptbr: 32'h5000});
        do_req(20'h00999, 32'h5000, 3'd1, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b1;
        do_fill(24'h00333, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_fill_no_ack", 64'(ack_valid), 64'd0);
        end
        push_ack(3'd2, 24'd0, 2'b10, 1'b0, 1);
        do_req(20'h00999, 32'h5000, 3'd2, 0);
        wait_idle("slots_cleared");

        chk("ack_queue_empty", 64'(exp_ack.size()), 64'd0);
        chk("walk_queue_empty", 64'(exp_walk.size()), 64'd0);
        chk("snoop_queue_empty", 64'(exp_snoop.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
